cordic_iter_ctrl: RTL and testbench
===================================

// Module: cordic_iter_ctrl
// PURPOSE
//  Sequencer for one CORDIC pass over the x/y/z add-sub register units.
//  - Accepts a start pulse and issues a one-cycle load to all units.
//  - Runs ITERS micro-rotations, driving the shift index (barrel shifts, atan LUT address),
//    the per-unit add/sub selects and the stop hold.
//  - Freezes the units and pulses done.
//  - Sits between the top-level command interface and the datapath units.
// PARAMETERS
//  ITERS  16  micro-rotations per pass; 1 <= ITERS <= 2**CNT_W
//  CNT_W  4   width of iteration counter / shift index
// PORTS
//  clk     in   1      rising-edge clock, the only clock
//  reset   in   1      synchronous, active-high
//  start   in   1      request a pass; sampled in IDLE or DONE only
//  z_msb   in   1      sign of z unit's registered value (1 = negative)
//  y_msb   in   1      sign of y unit's registered value (1 = negative)
//  mode    in   1      0 = rotation, 1 = vectoring (only with CORDIC_VECTOR_EN)
//  ld      out  1      drives reset input of x/y/z units: load initial values
//  stop    out  1      drives stop input of x/y/z units: hold registers
//  shift   out  CNT_W  current iteration index i (shift amount, atan addr)
//  cin_x   out  1      x unit select: 1 = subtract, 0 = add
//  cin_y   out  1      y unit select: 1 = subtract, 0 = add
//  cin_z   out  1      z unit select: 1 = subtract, 0 = add
//  busy    out  1      high in LOAD and ITER
//  done    out  1      one-cycle pulse; results valid and frozen
// BEHAVIOUR
//  - State register: IDLE, LOAD, ITER, DONE. All outputs decode from state and counter (Moore),
//    except cin_*, which follow the sign inputs combinationally.
//  - Reset: state=IDLE, cnt=0, ld=0, stop=1, shift=0, busy=0, done=0, cin_*=0.
//  - IDLE: stop=1. start=1 -> LOAD.
//  - LOAD (1 cycle): ld=1, stop=0, busy=1, cnt<=0 -> ITER.
//  - ITER (ITERS cycles): stop=0, busy=1, shift=cnt, cnt increments each cycle.
//    cnt==ITERS-1 -> DONE; otherwise stay in ITER.
//  - DONE (1 cycle): done=1, stop=1, shift=0, cin_*=0.
//    start=1 -> LOAD (back-to-back pass); otherwise -> IDLE.
//  - Direction d_pos (d=+1) is computed from the current-cycle sign input only when state=ITER:
//    rotation d_pos = ~z_msb. Then cin_x = d_pos, cin_y = ~d_pos, cin_z = d_pos.
//    Outside ITER all cin_* = 0.
//  - Latency: start sampled at edge T.
//    LOAD occupies cycle T+1; ITER occupies cycles T+2 .. T+1+ITERS; done=1 in cycle T+2+ITERS.
//  - start while busy: ignored, no queueing.
//  - Reset mid-pass: IDLE on the next cycle, stop=1, units keep partial values, no done pulse.
//  - Counter never wraps: exit is on cnt==ITERS-1; ITERS=2**CNT_W is legal.
// CONFIGURATION
//  CORDIC_VECTOR_EN defined:
//    - mode port exists and is latched at start acceptance; it is stable for the whole pass.
//    - latched mode=1 (vectoring): d_pos = y_msb.
//    - latched mode=0 (rotation): d_pos = ~z_msb.
//  CORDIC_VECTOR_EN undefined:
//    - mode port is absent; rotation only, d_pos = ~z_msb.
// TESTING
//  1 reset held 2 cycles -> ld=0 stop=1 busy=0 done=0 shift=0 cin_*=0.
//  2 ITERS=16, start pulse at T, z_msb=0 -> ld=1 at T+1; shift 0..15 over T+2..T+17
//    with cin_x=1 cin_y=0 cin_z=1; done=1 only at T+18, stop=1 from T+18.
//  3 z_msb toggled each cycle during ITER -> cin_x/cin_y/cin_z flip in the same cycle;
//    stop stays 0.
//  4 start held high from T+3 to T+10 (busy) -> no effect;
//    start=1 in the DONE cycle -> LOAD next cycle with ld=1, fresh shift=0 sequence.
//  5 reset asserted while shift=7 -> next cycle IDLE, stop=1, busy=0; done never pulses.
//  6 CORDIC_VECTOR_EN, mode=1 at start, y_msb=1 then 0 -> cin_x=1 then 0,
//    cin_y=0 then 1, cin_z=1 then 0; z_msb ignored.

Source files
------------

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: sequences one CORDIC pass over the x/y/z add-sub units.
// A start request loads the units for one cycle. The block then runs ITERS
// micro-rotations, driving the shift index and the add/sub selects. Finally it
// freezes the units and pulses done for one cycle.
// Optional build macro: CORDIC_VECTOR_EN adds the mode port (vectoring support).
//
// state | meaning
// IDLE  | waiting for start, units held (stop=1)
// LOAD  | one cycle, units take their initial values (ld=1)
// ITER  | micro-rotation cnt, shift=cnt, add/sub selects follow the sign input
// DONE  | one cycle, results frozen, done=1; start here begins the next pass
module cordic_iter_ctrl #(
    parameter int ITERS = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             z_msb,
    input  logic             y_msb,
`ifdef CORDIC_VECTOR_EN
    input  logic             mode,
`endif
    output logic             ld,
    output logic             stop,
    output logic [CNT_W-1:0] shift,
    output logic             cin_x,
    output logic             cin_y,
    output logic             cin_z,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Exit compares against the last index so ITERS == 2**CNT_W never needs a wrap.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ITERS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d_pos;
    logic             accept;

    // A request is only honoured when the units are not mid-pass.
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    // State and iteration counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CORDIC_VECTOR_EN
    logic mode_q;

    // Mode is captured with the start request and held for the whole pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= 1'b0;
        end else if (accept) begin
            mode_q <= mode;
        end
    end

    // Vectoring drives y towards zero; rotation drives z towards zero.
    always_comb begin
        d_pos = mode_q ? y_msb : ~z_msb;
    end
`else
    logic unused_y_msb;
    assign unused_y_msb = y_msb;

    // Rotation only: rotate positively while z is non-negative.
    always_comb begin
        d_pos = ~z_msb;
    end
`endif

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = accept ? LOAD : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: Moore from state/counter, except the selects, which track the sign input.
    always_comb begin
        ld    = 1'b0;
        stop  = 1'b1;
        shift = '0;
        cin_x = 1'b0;
        cin_y = 1'b0;
        cin_z = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            LOAD: begin
                ld   = 1'b1;
                stop = 1'b0;
                busy = 1'b1;
            end
            ITER: begin
                stop  = 1'b0;
                busy  = 1'b1;
                shift = cnt_q;
                cin_x = d_pos;
                cin_y = ~d_pos;
                cin_z = d_pos;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                stop = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: reset/table vectors, hand-written pass sequences,
// then randomized traffic against a cycle-count reference model.
module tb_cordic_iter_ctrl;

    localparam int ITERS = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset, start, z_msb, y_msb, mode;
    logic             ld, stop, cin_x, cin_y, cin_z, busy, done;
    logic [CNT_W-1:0] shift;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cordic_iter_ctrl #(.ITERS(ITERS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .z_msb (z_msb),
        .y_msb (y_msb),
`ifdef CORDIC_VECTOR_EN
        .mode  (mode),
`endif
        .ld    (ld),
        .stop  (stop),
        .shift (shift),
        .cin_x (cin_x),
        .cin_y (cin_y),
        .cin_z (cin_z),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       rst, st, z, y;
        logic       e_ld, e_stop, e_busy, e_done;
        logic [3:0] e_shift;
        logic       e_cx, e_cy, e_cz;
    } vec_t;

    vec_t vecs[9];

    // Reference model: t counts cycles since the accepted start.
    // 0 = idle, 1 = load, 2..ITERS+1 = rotations (index t-2), ITERS+2 = done.
    int   t_m;
    logic mode_m;

    task automatic model_edge();
        if (reset) begin
            t_m    = 0;
            mode_m = 1'b0;
        end else if (t_m == 0 || t_m == ITERS + 2) begin
            if (start) begin
                t_m = 1;
`ifdef CORDIC_VECTOR_EN
                mode_m = mode;
`endif
            end else begin
                t_m = 0;
            end
        end else begin
            t_m = t_m + 1;
        end
    endtask

    task automatic model_check();
        bit in_rot;
        bit dp;
        in_rot = (t_m >= 2) && (t_m <= ITERS + 1);
        dp     = mode_m ? y_msb : !z_msb;
        chk("rnd_ld",    ld,    int'(t_m == 1));
        chk("rnd_busy",  busy,  int'(t_m >= 1 && t_m <= ITERS + 1));
        chk("rnd_stop",  stop,  int'(!(t_m >= 1 && t_m <= ITERS + 1)));
        chk("rnd_done",  done,  int'(t_m == ITERS + 2));
        chk("rnd_shift", shift, in_rot ? t_m - 2 : 0);
        chk("rnd_cin_x", cin_x, int'(in_rot && dp));
        chk("rnd_cin_y", cin_y, int'(in_rot && !dp));
        chk("rnd_cin_z", cin_z, int'(in_rot && dp));
    endtask

    initial begin
        int done_seen;
        //          rst st z y  ld stp bsy dn sh  cx cy cz
        vecs[0] = '{1, 0, 0, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0};
        vecs[1] = '{1, 0, 0, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0};
        vecs[2] = '{0, 1, 0, 0, 1, 0, 1, 0, 4'd0, 0, 0, 0};
        vecs[3] = '{0, 0, 0, 0, 0, 0, 1, 0, 4'd0, 1, 0, 1};
        vecs[4] = '{0, 0, 1, 0, 0, 0, 1, 0, 4'd1, 0, 1, 0};
        vecs[5] = '{0, 0, 0, 1, 0, 0, 1, 0, 4'd2, 1, 0, 1};
        vecs[6] = '{0, 1, 1, 0, 0, 0, 1, 0, 4'd3, 0, 1, 0};
        vecs[7] = '{1, 0, 0, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0};
        vecs[8] = '{0, 0, 1, 1, 0, 1, 0, 0, 4'd0, 0, 0, 0};

        reset = 1'b1; start = 1'b0; z_msb = 1'b0; y_msb = 1'b0; mode = 1'b0;

        // Table vectors: inputs held across the edge, outputs checked at the following negedge.
        for (int i = 0; i < 9; i++) begin
            reset = vecs[i].rst; start = vecs[i].st;
            z_msb = vecs[i].z;   y_msb = vecs[i].y;
            tick();
            chk($sformatf("vec%0d_ld", i),    ld,    vecs[i].e_ld);
            chk($sformatf("vec%0d_stop", i),  stop,  vecs[i].e_stop);
            chk($sformatf("vec%0d_busy", i),  busy,  vecs[i].e_busy);
            chk($sformatf("vec%0d_done", i),  done,  vecs[i].e_done);
            chk($sformatf("vec%0d_shift", i), shift, vecs[i].e_shift);
            chk($sformatf("vec%0d_cin_x", i), cin_x, vecs[i].e_cx);
            chk($sformatf("vec%0d_cin_y", i), cin_y, vecs[i].e_cy);
            chk($sformatf("vec%0d_cin_z", i), cin_z, vecs[i].e_cz);
        end

        // Full pass with start held high while busy (T+3..T+10), then back-to-back start in DONE.
        reset = 1'b0; z_msb = 1'b0; y_msb = 1'b1; start = 1'b1;
        tick();
        chk("pass_ld", ld, 1);
        start = 1'b0;
        for (int i = 0; i < ITERS; i++) begin
            start = (i >= 1 && i <= 8);
            tick();
            chk($sformatf("pass_shift%0d", i), shift, i);
            chk("pass_cin_x", cin_x, 1);
            chk("pass_cin_y", cin_y, 0);
            chk("pass_cin_z", cin_z, 1);
            chk("pass_stop",  stop,  0);
            chk("pass_done",  done,  0);
            chk("pass_ld_low", ld, 0);
        end
        start = 1'b0;
        tick();
        chk("pass_done_pulse", done,  1);
        chk("pass_done_stop",  stop,  1);
        chk("pass_done_shift", shift, 0);
        chk("pass_done_cin_x", cin_x, 0);
        start = 1'b1;
        tick();
        chk("b2b_ld",   ld,   1);
        chk("b2b_busy", busy, 1);
        start = 1'b0;

        // Second pass: reset while shift == 7, then no done pulse may appear.
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("b2b_shift%0d", i), shift, i);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_stop", stop, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ld",   ld,   0);
        done_seen = 0;
        for (int i = 0; i < ITERS + 4; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("rst_mid_no_done", done_seen, 0);

        // Randomized traffic against the reference model.
        reset = 1'b1;
        tick();
        t_m = 0; mode_m = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 5) == 0);
            z_msb = 1'($urandom);
            y_msb = 1'($urandom);
            mode  = 1'($urandom);
            @(posedge clk);
            model_edge();
            @(negedge clk);
            model_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
